vc_input_port_buffer: RTL

// Input-port buffer for one router port: NUM_VC independent per-VC flit FIFOs. Each VC has its own

---
 rtl/vc_input_port_buffer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vc_input_port_buffer.sv
// Input-port buffer: NUM_VC per-VC flit FIFOs, each with an IDLE/VA/SA
// packet FSM feeding VC and switch allocation; one credit per flit read.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wr_valid_i/vc/label/data   flit write from upstream link
//   route_i                    output port latched with HEAD/HEADTAIL
//   vc_req_o, vc_grant_i       downstream-VC allocation handshake
//   vc_new_i                   granted downstream VC, VC_W slice per VC
//   sw_req_o, sw_grant_i       switch allocation handshake
//   out_*_o                    registered flit presented to crossbar
//   credit_o, credit_vc_o      credit returned upstream per flit read
//   empty_o, full_o, err_o     per-VC status and protocol-error pulse

module vc_input_port_buffer #(
    parameter int NUM_VC      = 4,
    parameter int BUFFER_SIZE = 8,
    parameter int DATA_W      = 32,
    parameter int PORT_W      = 3,
    parameter int VC_W        = $clog2(NUM_VC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid_i,
    input  logic [VC_W-1:0]        wr_vc_i,
    input  logic [1:0]             wr_label_i,
    input  logic [DATA_W-1:0]      wr_data_i,
    input  logic [PORT_W-1:0]      route_i,
    output logic [NUM_VC-1:0]      vc_req_o,
    input  logic [NUM_VC-1:0]      vc_grant_i,
    input  logic [NUM_VC*VC_W-1:0] vc_new_i,
    output logic [NUM_VC-1:0]      sw_req_o,
    input  logic [NUM_VC-1:0]      sw_grant_i,
    output logic                   out_valid_o,
    output logic [1:0]             out_label_o,
    output logic [DATA_W-1:0]      out_data_o,
    output logic [VC_W-1:0]        out_vc_o,
    output logic [PORT_W-1:0]      out_port_o,
    output logic                   credit_o,
    output logic [VC_W-1:0]        credit_vc_o,
    output logic [NUM_VC-1:0]      empty_o,
    output logic [NUM_VC-1:0]      full_o,
    output logic [NUM_VC-1:0]      err_o
);

    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int FL_W  = DATA_W + 2;

    localparam logic [1:0] L_HEAD = 2'd0;
    localparam logic [1:0] L_TAIL = 2'd2;
    localparam logic [1:0] L_HT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VA,
        S_SA
    } state_e;

    state_e            state_q [NUM_VC];
    state_e            state_d [NUM_VC];
    logic [NUM_VC-1:0] eop_q;
    logic [NUM_VC-1:0] eop_d;
    logic [PORT_W-1:0] port_q  [NUM_VC];
    logic [PORT_W-1:0] port_d  [NUM_VC];
    logic [VC_W-1:0]   dvc_q   [NUM_VC];
    logic [VC_W-1:0]   dvc_d   [NUM_VC];
    logic [PTR_W-1:0]  wptr_q  [NUM_VC];
    logic [PTR_W-1:0]  wptr_d  [NUM_VC];
    logic [PTR_W-1:0]  rptr_q  [NUM_VC];
    logic [PTR_W-1:0]  rptr_d  [NUM_VC];
    logic [CNT_W-1:0]  cnt_q   [NUM_VC];
    logic [CNT_W-1:0]  cnt_d   [NUM_VC];
    logic [FL_W-1:0]   mem_q   [NUM_VC][BUFFER_SIZE];

    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] sw_req;
    logic [NUM_VC-1:0] wr_en;
    logic [NUM_VC-1:0] pop;
    logic [NUM_VC-1:0] err_d;
    logic [NUM_VC-1:0] err_q;
    logic              wr_head;
    logic              pop_any;
    logic [FL_W-1:0]   pop_flit;
    logic [VC_W-1:0]   pop_vc;
    logic [VC_W-1:0]   pop_dvc;
    logic [PORT_W-1:0] pop_port;

    logic              out_valid_q;
    logic [1:0]        out_label_q;
    logic [DATA_W-1:0] out_data_q;
    logic [VC_W-1:0]   out_vc_q;
    logic [PORT_W-1:0] out_port_q;
    logic [VC_W-1:0]   credit_vc_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_head = (wr_label_i == L_HEAD) || (wr_label_i == L_HT);

    always_comb begin
        empty    = '0;
        full     = '0;
        sw_req   = '0;
        vc_req_o = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v]    = (cnt_q[v] == '0);
            full[v]     = (cnt_q[v] == CNT_W'(BUFFER_SIZE));
            sw_req[v]   = (state_q[v] == S_SA) && (cnt_q[v] != '0);
            vc_req_o[v] = (state_q[v] == S_VA);
        end
    end

    // Write acceptance and grant checking. The switch grant is served at
    // the lowest requesting index; every other set grant bit is an error.
    always_comb begin
        wr_en    = '0;
        err_d    = '0;
        pop      = '0;
        pop_any  = 1'b0;
        pop_vc   = '0;
        pop_flit = '0;
        pop_dvc  = '0;
        pop_port = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_valid_i && (wr_vc_i == VC_W'(v))) begin
                if (full[v]) begin
                    err_d[v] = 1'b1;
                end else if (state_q[v] == S_IDLE) begin
                    if (wr_head && empty[v]) wr_en[v] = 1'b1;
                    else                     err_d[v] = 1'b1;
                end else begin
                    if (!wr_head && !eop_q[v]) wr_en[v] = 1'b1;
                    else                       err_d[v] = 1'b1;
                end
            end
            if (vc_grant_i[v] && (state_q[v] == S_IDLE)) err_d[v] = 1'b1;
            if (sw_grant_i[v]) begin
                if (sw_req[v] && !pop_any) begin
                    pop[v]   = 1'b1;
                    pop_any  = 1'b1;
                    pop_vc   = VC_W'(v);
                    pop_flit = mem_q[v][rptr_q[v]];
                    pop_dvc  = dvc_q[v];
                    pop_port = port_q[v];
                end else begin
                    err_d[v] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        eop_d = eop_q;
        for (int v = 0; v < NUM_VC; v++) begin
            state_d[v] = state_q[v];
            port_d[v]  = port_q[v];
            dvc_d[v]   = dvc_q[v];
            wptr_d[v]  = wr_en[v] ? ptr_inc(wptr_q[v]) : wptr_q[v];
            rptr_d[v]  = pop[v] ? ptr_inc(rptr_q[v]) : rptr_q[v];
            cnt_d[v]   = cnt_q[v] + CNT_W'(wr_en[v]) - CNT_W'(pop[v]);
            unique case (state_q[v])
                S_IDLE: begin
                    if (wr_en[v]) begin
                        state_d[v] = S_VA;
                        eop_d[v]   = (wr_label_i == L_HT);
                        port_d[v]  = route_i;
                    end
                end
                S_VA: begin
                    if (vc_grant_i[v]) begin
                        dvc_d[v]   = vc_new_i[v*VC_W +: VC_W];
                        state_d[v] = S_SA;
                    end
                    if (wr_en[v] && (wr_label_i == L_TAIL)) eop_d[v] = 1'b1;
                end
                S_SA: begin
                    if (wr_en[v] && (wr_label_i == L_TAIL)) eop_d[v] = 1'b1;
                    // label bit 1 marks TAIL and HEADTAIL
                    if (pop[v] && mem_q[v][rptr_q[v]][FL_W-1]) begin
                        state_d[v] = S_IDLE;
                        eop_d[v]   = 1'b0;
                    end
                end
                default: state_d[v] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eop_q       <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
            out_label_q <= '0;
            out_data_q  <= '0;
            out_vc_q    <= '0;
            out_port_q  <= '0;
            credit_vc_q <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= S_IDLE;
                port_q[v]  <= '0;
                dvc_q[v]   <= '0;
                wptr_q[v]  <= '0;
                rptr_q[v]  <= '0;
                cnt_q[v]   <= '0;
            end
        end else begin
            eop_q       <= eop_d;
            err_q       <= err_d;
            out_valid_q <= pop_any;
            out_label_q <= pop_flit[FL_W-1:DATA_W];
            out_data_q  <= pop_flit[DATA_W-1:0];
            out_vc_q    <= pop_dvc;
            out_port_q  <= pop_port;
            credit_vc_q <= pop_vc;
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= state_d[v];
                port_q[v]  <= port_d[v];
                dvc_q[v]   <= dvc_d[v];
                wptr_q[v]  <= wptr_d[v];
                rptr_q[v]  <= rptr_d[v];
                cnt_q[v]   <= cnt_d[v];
            end
        end
    end

    // Flit storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_en[v]) mem_q[v][wptr_q[v]] <= {wr_label_i, wr_data_i};
        end
    end

    assign sw_req_o    = sw_req;
    assign empty_o     = empty;
    assign full_o      = full;
    assign err_o       = err_q;
    assign out_valid_o = out_valid_q;
    assign out_label_o = out_label_q;
    assign out_data_o  = out_data_q;
    assign out_vc_o    = out_vc_q;
    assign out_port_o  = out_port_q;
    assign credit_o    = out_valid_q;
    assign credit_vc_o = credit_vc_q;

endmodule
